// File: rtl/arb_mux_if.sv
// rtl/arb_mux_if.sv - handshake bundle between producers, arb_mux and its consumer
interface arb_mux_if #(
    parameter int WIDTH = 16,
    parameter int NCH   = 8,
    parameter int SELW  = 3
);
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SELW-1:0]      out_ch;
    logic                 err;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_ch, err
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_ch, err
    );
endinterface

// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - registered N:1 valid/ready mux, explicit select or round-robin
// Optional X/out-of-range select checking on err is enabled by ARB_MUX_ERR_CHECK_EN.
module arb_mux #(
    parameter int WIDTH = 16,
    parameter int NCH   = 8,
    parameter int SELW  = 3
) (
    input  logic      clk,
    input  logic      rst,
    arb_mux_if.slave  bus
);
    logic [SELW-1:0]  ptr;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [SELW-1:0]  ch_q;

    logic             slot_free;
    logic             sel_ok;
    logic             sel_valid;
    logic             hi_found;
    logic             lo_found;
    logic [SELW-1:0]  hi_ch;
    logic [SELW-1:0]  lo_ch;
    logic             cand_ok;
    logic [SELW-1:0]  cand_ch;
    logic             grant;
    logic [WIDTH-1:0] grant_data;
    logic [NCH-1:0]   rdy;

    always_comb begin
        slot_free = !valid_q || bus.out_ready;
        sel_ok    = 1'b0;
        sel_valid = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (bus.sel == SELW'(k)) begin
                sel_ok    = 1'b1;
                sel_valid = bus.in_valid[k];
            end
        end
        // Descending scan leaves the lowest valid index at/above ptr in hi_ch and
        // the lowest below ptr in lo_ch; hi wins, lo covers the wrap-around.
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_ch    = '0;
        lo_ch    = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (bus.in_valid[k]) begin
                if (SELW'(k) >= ptr) begin
                    hi_found = 1'b1;
                    hi_ch    = SELW'(k);
                end else begin
                    lo_found = 1'b1;
                    lo_ch    = SELW'(k);
                end
            end
        end
        if (bus.mode) begin
            cand_ok = hi_found || lo_found;
            cand_ch = hi_found ? hi_ch : lo_ch;
        end else begin
            cand_ok = sel_ok && sel_valid;
            cand_ch = bus.sel;
        end
        grant      = cand_ok && slot_free && !rst;
        grant_data = '0;
        rdy        = '0;
        for (int k = 0; k < NCH; k++) begin
            if (cand_ch == SELW'(k)) begin
                grant_data = bus.in_data[k*WIDTH +: WIDTH];
                rdy[k]     = grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            ptr     <= '0;
        end else if (grant) begin
            valid_q <= 1'b1;
            data_q  <= grant_data;
            ch_q    <= cand_ch;
            if (bus.mode) begin
                ptr <= (cand_ch == SELW'(NCH - 1)) ? '0 : cand_ch + SELW'(1);
            end
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;

`ifdef ARB_MUX_ERR_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= ((^{bus.mode, bus.sel, bus.in_valid, bus.out_ready}) === 1'bx)
                  || (!bus.mode && !sel_ok && slot_free);
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule
